// File: rtl/writeback_arbiter_pkg.sv
// Shared parameters and types for the writeback arbiter slice.
package writeback_arbiter_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int VALUE_W      = 32;
    localparam int STARVE_LIMIT = 3;
    localparam int NUM_REGS     = 1 << REG_ADDR_W;

    typedef enum logic [0:0] {
        NORMAL   = 1'b0,
        MEM_PRIO = 1'b1
    } wb_state_t;

    // Saturating 2-bit increment so the stall counter can never wrap back to zero.
    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Bus bundle for the writeback arbiter: two result channels, issue/hazard ports, RF write port.
interface writeback_arbiter_if;
    import writeback_arbiter_pkg::*;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [VALUE_W-1:0]    alu_data;
    logic                  alu_ready;

    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [VALUE_W-1:0]    mem_data;
    logic                  mem_ready;

    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;

    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  busy1;
    logic                  busy2;

    logic [REG_ADDR_W-1:0] rd;
    logic [VALUE_W-1:0]    writeData;
    logic                  RegWrite;

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
               issue_valid, issue_rd, rs1, rs2,
        output alu_ready, mem_ready, busy1, busy2, rd, writeData, RegWrite
    );

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
               issue_valid, issue_rd, rs1, rs2,
        input  alu_ready, mem_ready, busy1, busy2, rd, writeData, RegWrite
    );

endinterface

// File: rtl/writeback_arbiter_reg_scoreboard.sv
// Per-register pending bits: set by issue, cleared by the register-file write, queried by hazard ports.
module reg_scoreboard
    import writeback_arbiter_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_set_valid,
    input  logic [REG_ADDR_W-1:0] i_set_rd,
    input  logic                  i_clr_valid,
    input  logic [REG_ADDR_W-1:0] i_clr_rd,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    output logic                  o_busy1,
    output logic                  o_busy2
);

    localparam logic [NUM_REGS-1:0] ONE_C  = {{(NUM_REGS-1){1'b0}}, 1'b1};
    localparam logic [NUM_REGS-1:0] ZERO_C = {NUM_REGS{1'b0}};
    localparam logic [REG_ADDR_W-1:0] X0_C = {REG_ADDR_W{1'b0}};

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [NUM_REGS-1:0] w_pending_next;

    // Set is applied after clear so a same-cycle reissue keeps the register pending; x0 is never tracked.
    assign w_set_mask     = (i_set_valid && (i_set_rd != X0_C)) ? (ONE_C << i_set_rd) : ZERO_C;
    assign w_clr_mask     = i_clr_valid ? (ONE_C << i_clr_rd) : ZERO_C;
    assign w_pending_next = ((r_pending & ~w_clr_mask) | w_set_mask) & ~ONE_C;

    // Pending-bit storage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending <= ZERO_C;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    assign o_busy1 = (i_rs1 != X0_C) && r_pending[i_rs1];
    assign o_busy2 = (i_rs2 != X0_C) && r_pending[i_rs2];

endmodule

// File: rtl/writeback_arbiter.sv
// Arbitrates ALU and load results onto one register-file write port, with load anti-starvation.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    writeback_arbiter_if.slave  bus
);

    localparam logic [1:0]            STALL_LIMIT_C = 2'(STARVE_LIMIT);
    localparam logic [REG_ADDR_W-1:0] X0_C          = {REG_ADDR_W{1'b0}};

    wb_state_t             r_state;
    logic [1:0]            r_stall;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [VALUE_W-1:0]    r_data;
    logic                  r_wr;

    logic       w_alu_ready;
    logic       w_mem_ready;
    logic       w_alu_fire;
    logic       w_mem_fire;
    logic [1:0] w_stall_next;
    logic       w_busy1;
    logic       w_busy2;

    // Ready depends only on state and the opposite channel's valid, so at most one channel fires.
    always_comb begin
        w_alu_ready = 1'b0;
        w_mem_ready = 1'b0;
        if (reset) begin
            w_alu_ready = 1'b0;
            w_mem_ready = 1'b0;
        end else begin
            case (r_state)
                NORMAL: begin
                    w_alu_ready = 1'b1;
                    w_mem_ready = !bus.alu_valid;
                end
                MEM_PRIO: begin
                    w_alu_ready = !bus.mem_valid;
                    w_mem_ready = 1'b1;
                end
                default: begin
                    w_alu_ready = 1'b0;
                    w_mem_ready = 1'b0;
                end
            endcase
        end
    end

    assign w_alu_fire = bus.alu_valid && w_alu_ready;
    assign w_mem_fire = bus.mem_valid && w_mem_ready;

    // Stall count of consecutive refused load beats.
    always_comb begin
        w_stall_next = 2'd0;
        if (w_mem_fire || !bus.mem_valid) begin
            w_stall_next = 2'd0;
        end else begin
            w_stall_next = sat_inc2(r_stall);
        end
    end

    // Priority FSM and stall counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= NORMAL;
            r_stall <= 2'd0;
        end else begin
            r_stall <= w_stall_next;
            case (r_state)
                NORMAL:   r_state <= (w_stall_next == STALL_LIMIT_C) ? MEM_PRIO : NORMAL;
                MEM_PRIO: r_state <= w_mem_fire ? NORMAL : MEM_PRIO;
                default:  r_state <= NORMAL;
            endcase
        end
    end

    // Register-file write port; a beat to x0 is consumed but never written.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd   <= X0_C;
            r_data <= {VALUE_W{1'b0}};
            r_wr   <= 1'b0;
        end else if (w_alu_fire) begin
            r_rd   <= bus.alu_rd;
            r_data <= bus.alu_data;
            r_wr   <= (bus.alu_rd != X0_C);
        end else if (w_mem_fire) begin
            r_rd   <= bus.mem_rd;
            r_data <= bus.mem_data;
            r_wr   <= (bus.mem_rd != X0_C);
        end else begin
            r_wr   <= 1'b0;
        end
    end

    reg_scoreboard u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .i_set_valid (bus.issue_valid),
        .i_set_rd    (bus.issue_rd),
        .i_clr_valid (r_wr),
        .i_clr_rd    (r_rd),
        .i_rs1       (bus.rs1),
        .i_rs2       (bus.rs2),
        .o_busy1     (w_busy1),
        .o_busy2     (w_busy2)
    );

    assign bus.alu_ready = w_alu_ready;
    assign bus.mem_ready = w_mem_ready;
    assign bus.busy1     = w_busy1;
    assign bus.busy2     = w_busy2;
    assign bus.rd        = r_rd;
    assign bus.writeData = r_data;
    assign bus.RegWrite  = r_wr;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: directed scenarios then randomized traffic vs a reference model.
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    writeback_arbiter_if bus();
    writeback_arbiter dut (.clock(clock), .reset(reset), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    // Reference model: priority mode, run of starved load cycles, pending set, write in flight.
    bit         m_prio;
    int         m_starved;
    bit         pend[32];
    bit         m_out_wr;
    logic [4:0] m_out_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_prio    = 1'b0;
        m_starved = 0;
        m_out_wr  = 1'b0;
        m_out_rd  = 5'd0;
        foreach (pend[i]) pend[i] = 1'b0;
        exp_q.delete();
    endtask

    // Monitor: every cycle the write port must match the scoreboard head or be idle.
    always @(negedge clock) begin
        if (!reset) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("missed_write", 32'(exp_q[0].cyc), 32'(cyc));
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                chk("regwrite", 32'(bus.RegWrite), 32'd1);
                chk("rd", 32'(bus.rd), 32'(exp_q[0].rd));
                chk("writeData", bus.writeData, exp_q[0].data);
                void'(exp_q.pop_front());
            end else begin
                chk("regwrite_idle", 32'(bus.RegWrite), 32'd0);
            end
        end
    end

    task automatic drive_cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                               input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                               input logic iv, input logic [4:0] ird,
                               input logic [4:0] r1, input logic [4:0] r2);
        bit ar, mr, af, mf;
        @(negedge clock);
        bus.alu_valid = av;  bus.alu_rd = ard; bus.alu_data = ad;
        bus.mem_valid = mv;  bus.mem_rd = mrd; bus.mem_data = md;
        bus.issue_valid = iv; bus.issue_rd = ird;
        bus.rs1 = r1; bus.rs2 = r2;
        #1;
        ar = m_prio ? !mv : 1'b1;
        mr = m_prio ? 1'b1 : !av;
        chk("alu_ready", 32'(bus.alu_ready), 32'(ar));
        chk("mem_ready", 32'(bus.mem_ready), 32'(mr));
        chk("busy1", 32'(bus.busy1), 32'((r1 != 5'd0) && pend[r1]));
        chk("busy2", 32'(bus.busy2), 32'((r2 != 5'd0) && pend[r2]));
        af = av && ar;
        mf = mv && mr;
        if (m_out_wr) pend[m_out_rd] = 1'b0;
        if (iv && ird != 5'd0) pend[ird] = 1'b1;
        m_out_wr = 1'b0;
        if (af) begin
            m_out_wr = (ard != 5'd0);
            m_out_rd = ard;
            if (ard != 5'd0) exp_q.push_back('{cyc + 1, ard, ad});
        end else if (mf) begin
            m_out_wr = (mrd != 5'd0);
            m_out_rd = mrd;
            if (mrd != 5'd0) exp_q.push_back('{cyc + 1, mrd, md});
        end
        m_starved = (mv && !mf) ? m_starved + 1 : 0;
        if (m_prio && mf) m_prio = 1'b0;
        else if (!m_prio && m_starved >= STARVE_LIMIT) m_prio = 1'b1;
    endtask

    task automatic idle(input int n, input logic [4:0] r1);
        for (int i = 0; i < n; i++)
            drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, r1, 5'd0);
    endtask

    // Assert reset just after an edge, offer beats during it, and check the cleared state.
    task automatic apply_reset(input int n, input logic [4:0] r1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_data = 32'h1234_5678;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'h8765_4321;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd6;
        bus.rs1 = r1; bus.rs2 = 5'd6;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            #1;
            chk("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
            chk("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
            chk("rst_regwrite", 32'(bus.RegWrite), 32'd0);
            chk("rst_rd", 32'(bus.rd), 32'd0);
            chk("rst_writeData", bus.writeData, 32'd0);
            chk("rst_busy1", 32'(bus.busy1), 32'd0);
            chk("rst_busy2", 32'(bus.busy2), 32'd0);
        end
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0; bus.issue_valid = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
        bus.mem_valid = 1'b0; bus.mem_rd = 5'd0; bus.mem_data = 32'd0;
        bus.issue_valid = 1'b0; bus.issue_rd = 5'd0;
        bus.rs1 = 5'd0; bus.rs2 = 5'd0;
        model_reset();
        apply_reset(3, 5'd0);

        // Single ALU write.
        drive_cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(2, 5'd0);

        // Simultaneous ALU and load: ALU first, load the following cycle.
        drive_cycle(1'b1, 5'd3, 32'hA1A1_0003, 1'b1, 5'd4, 32'hB2B2_0004, 1'b0, 5'd0, 5'd0, 5'd0);
        drive_cycle(1'b0, 5'd0, 32'd0,         1'b1, 5'd4, 32'hB2B2_0004, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(2, 5'd0);

        // Load starved by a continuous ALU stream until priority flips.
        for (int i = 0; i < 6; i++)
            drive_cycle(1'b1, 5'(10 + i), 32'hC000_0000 + 32'(i), 1'b1, 5'd7, 32'h7777_0007,
                        1'b0, 5'd0, 5'd0, 5'd0);
        idle(2, 5'd0);

        // Pending bit lifecycle on x9, including reissue in the write cycle.
        drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
        idle(2, 5'd9);
        drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0909_0909, 1'b0, 5'd0, 5'd9, 5'd9);
        idle(3, 5'd9);
        drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
        drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0909_1111, 1'b0, 5'd0, 5'd9, 5'd0);
        drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
        idle(3, 5'd9);

        // Beats and issues targeting x0.
        drive_cycle(1'b1, 5'd0, 32'hFFFF_0000, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0);
        idle(2, 5'd0);

        // Reset right after accepting a write to x12 that was pending.
        drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd12, 5'd0);
        drive_cycle(1'b1, 5'd12, 32'h1212_1212, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd12, 5'd0);
        apply_reset(2, 5'd12);
        idle(3, 5'd12);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic av, mv, iv;
            logic [4:0] ard, mrd, ird;
            av  = ($urandom_range(0, 99) < 65);
            mv  = ($urandom_range(0, 99) < 55);
            iv  = ($urandom_range(0, 99) < 40);
            ard = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            mrd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ird = 5'($urandom_range(0, 31));
            drive_cycle(av, ard, $urandom, mv, mrd, $urandom, iv, ird,
                        5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        idle(3, 5'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL take parameters from the shared specs package: REG_ADDR_W = 5, register address width; VALUE_W = 32, data width; STARVE_LIMIT = 3, consecutive mem stall cycles before mem priority.
REQ-002 SHALL have port clock  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports alu_valid in 1, alu_rd in REG_ADDR_W, alu_data in VALUE_W, alu_ready out 1  ALU result channel.
REQ-005 SHALL have ports mem_valid in 1, mem_rd in REG_ADDR_W, mem_data in VALUE_W, mem_ready out 1  load result channel.
REQ-006 SHALL have ports issue_valid in 1, issue_rd in REG_ADDR_W  decode marks a destination pending.
REQ-007 SHALL have ports rs1, rs2 in REG_ADDR_W; busy1, busy2 out 1  hazard query.
REQ-008 SHALL have ports rd out REG_ADDR_W, writeData out VALUE_W, RegWrite out 1  register-file write port, all registered.

Function
REQ-009 SHALL transfer a channel beat when valid && ready are both high at a rising edge; ready SHALL be combinational from state and the other channel's valid, never from its own valid.
REQ-010 SHALL accept at most one beat per cycle; the beat accepted at edge N drives rd/writeData/RegWrite=1 for exactly cycle N+1. Otherwise RegWrite = 0, rd/writeData hold.
REQ-011 SHALL implement states NORMAL and MEM_PRIO.
REQ-012 In NORMAL: alu_ready = 1; mem_ready = !alu_valid.
REQ-013 In MEM_PRIO: mem_ready = 1; alu_ready = !mem_valid.
REQ-014 SHALL keep a stall counter (2 bits) incremented each cycle mem_valid && !mem_ready, cleared on any mem transfer or when mem_valid = 0.
REQ-015 NORMAL -> MEM_PRIO when counter reaches STARVE_LIMIT; MEM_PRIO -> NORMAL on the edge of the next mem transfer.
REQ-016 A beat with rd = 0 SHALL be accepted (ready rules unchanged) but SHALL produce RegWrite = 0.
REQ-017 SHALL keep a pending bit per register (2^REG_ADDR_W bits); issue_valid with issue_rd != 0 sets pending[issue_rd].
REQ-018 A RegWrite = 1 output cycle SHALL clear pending[rd] at the end of that cycle.
REQ-019 Simultaneous set and clear of the same register SHALL leave it set (new issue wins).
REQ-020 busy1 = pending[rs1], busy2 = pending[rs2], combinational; register 0 SHALL never read busy.
REQ-021 Channel data SHALL be captured unmodified; no width conversion.

Reset
REQ-022 On reset high, asynchronously: RegWrite = 0, rd = 0, writeData = 0, all pending = 0, state = NORMAL, counter = 0.
REQ-023 Beats presented during reset SHALL be discarded; while reset is high both ready outputs SHALL be 0.
REQ-024 Reset mid-operation SHALL drop any in-flight write with no RegWrite pulse after release until a new transfer.

Structure
REQ-025 REG_ADDR_W, VALUE_W, STARVE_LIMIT and enum wb_state_t {NORMAL, MEM_PRIO} SHALL live in the shared specs package.
REQ-026 The pending-bit array and busy lookup SHALL be a sub-module reg_scoreboard; arbitration, FSM and output register stay in writeback_arbiter.

Verification
REQ-027 Reset then ALU beat rd=5, data=0xDEADBEEF -> next cycle RegWrite=1, rd=5, writeData=0xDEADBEEF; following cycle RegWrite=0.
REQ-028 alu_valid and mem_valid high together (rd=3 / rd=4) -> mem_ready=0, ALU write first, mem write next cycle.
REQ-029 alu_valid held high, mem_valid high (rd=7) -> after 3 stalled cycles MEM_PRIO, alu_ready=0, rd=7 written, then NORMAL.
REQ-030 issue rd=9 -> busy1=1 for rs1=9; mem write rd=9 -> busy1=0 after the RegWrite cycle; issue rd=9 on that same cycle -> busy1 stays 1.
REQ-031 ALU beat rd=0 -> accepted, RegWrite=0; issue rd=0 -> busy1 for rs1=0 stays 0.
REQ-032 Reset asserted in cycle after acceptance of rd=12 -> no RegWrite pulse, pending cleared, both readies 0 during reset.
